// File: rtl/program_counter_pkg.sv
// Shared CPU package: program-counter FSM states and counter widths.
// Used by program_counter (optional feature macro: PC_MISALIGN_TRAP_EN).
package program_counter_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        FAULT    = 2'd3
    } pc_state_e;

    localparam int PC_REDIRECT_CNT_W = 16;
    localparam int PC_BUBBLE_W       = 3;

endpackage

// File: rtl/program_counter_bubble_counter.sv
// Loadable down-counter timing the fetch bubble after a redirect.
// Flags zero, and the last non-zero value so the owner can leave one edge early.
module pc_bubble_counter
    import program_counter_pkg::*;
#(
    parameter int W = PC_BUBBLE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o,
    output logic         last_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load beats decrement so a back-to-back redirect restarts the bubble.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    assign last_o  = (count_q == W'(1));

endmodule

// File: rtl/program_counter.sv
// Fetch program counter with ROB redirect, dual-issue advance and flush freeze.
// Define PC_MISALIGN_TRAP_EN to trap misaligned redirect targets in FAULT.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int           XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int           REDIRECT_BUBBLE = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [XLEN-1:0]              jmp_address,
    input  logic                         write,
    input  logic                         plus_4,
    input  logic                         plus_8,
    input  logic                         delete_tagged,
    output logic [XLEN-1:0]              address,
    output logic                         address_valid,
    output logic [PC_REDIRECT_CNT_W-1:0] redirect_count,
    output logic                         misaligned
);

    pc_state_e                    state_q, state_d;
    logic [XLEN-1:0]              address_q, address_d;
    logic [PC_REDIRECT_CNT_W-1:0] redirect_count_q, redirect_count_d;
    logic                         misaligned_q, misaligned_d;

    logic                         bubble_load;
    logic                         bubble_dec;
    logic [PC_BUBBLE_W-1:0]       bubble_count;
    logic                         bubble_zero;
    logic                         bubble_last;
    logic                         accept_write;

    pc_bubble_counter #(
        .W(PC_BUBBLE_W)
    ) u_bubble (
        .clk          (clk),
        .reset        (reset),
        .load_i       (bubble_load),
        .load_value_i (PC_BUBBLE_W'(REDIRECT_BUBBLE)),
        .dec_i        (bubble_dec),
        .count_o      (bubble_count),
        .zero_o       (bubble_zero),
        .last_o       (bubble_last)
    );

    // Next-state: the per-state behaviour first, then a redirect overrides it.
    always_comb begin
        state_d          = state_q;
        address_d        = address_q;
        redirect_count_d = redirect_count_q;
        misaligned_d     = misaligned_q;
        address_valid    = 1'b0;
        bubble_load      = 1'b0;
        bubble_dec       = 1'b0;
        accept_write     = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                address_valid = !delete_tagged;
                if (!delete_tagged) begin
                    if (plus_8) begin
                        address_d = address_q + XLEN'(8);
                    end else if (plus_4) begin
                        address_d = address_q + XLEN'(4);
                    end
                end
            end
            REDIRECT: begin
                bubble_dec = 1'b1;
                if (bubble_last || bubble_zero) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        if (write && (state_q != FAULT)) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (jmp_address[1:0] != 2'b00) begin
                state_d      = FAULT;
                address_d    = address_q;
                misaligned_d = 1'b1;
                bubble_dec   = 1'b0;
            end else begin
                accept_write = 1'b1;
            end
`else
            accept_write = 1'b1;
`endif
        end

        if (accept_write) begin
            state_d     = REDIRECT;
            address_d   = jmp_address & ~XLEN'(3);
            bubble_load = 1'b1;
            bubble_dec  = 1'b0;
            if (redirect_count_q != '1) begin
                redirect_count_d = redirect_count_q + PC_REDIRECT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= BOOT;
            address_q        <= RESET_VECTOR;
            redirect_count_q <= '0;
            misaligned_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            address_q        <= address_d;
            redirect_count_q <= redirect_count_d;
            misaligned_q     <= misaligned_d;
        end
    end

    assign address        = address_q;
    assign redirect_count = redirect_count_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misaligned     = misaligned_q;
`else
    assign misaligned     = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (REDIRECT_BUBBLE = 2,
// default build without PC_MISALIGN_TRAP_EN).
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic [31:0] jmpAddress;
    logic        write;
    logic        plus4;
    logic        plus8;
    logic        deleteTagged;
    logic [31:0] address;
    logic        addressValid;
    logic [15:0] redirectCount;
    logic        misaligned;

    int testsRun;
    int testsFailed;

    program_counter #(
        .XLEN            (32),
        .RESET_VECTOR    (32'h0000_0000),
        .REDIRECT_BUBBLE (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .jmp_address    (jmpAddress),
        .write          (write),
        .plus_4         (plus4),
        .plus_8         (plus8),
        .delete_tagged  (deleteTagged),
        .address        (address),
        .address_valid  (addressValid),
        .redirect_count (redirectCount),
        .misaligned     (misaligned)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic w, input logic [31:0] jmp,
                                 input logic p4, input logic p8, input logic del);
        write        = w;
        jmpAddress   = jmp;
        plus4        = p4;
        plus8        = p8;
        deleteTagged = del;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Directed sequence: each check follows the edge it depends on by 1 ns.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        #12;
        checkOutput("reset_address", address, 32'h0);
        checkOutput("reset_valid", {31'b0, addressValid}, 32'h0);
        checkOutput("reset_count", {16'b0, redirectCount}, 32'h0);
        checkOutput("reset_misaligned", {31'b0, misaligned}, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("boot_valid", {31'b0, addressValid}, 32'h0);
        tick();
        checkOutput("run_valid", {31'b0, addressValid}, 32'h1);
        checkOutput("run_address0", address, 32'h0);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("plus4_x3", address, 32'd12);
        tick();
        checkOutput("plus4_x4", address, 32'd16);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("plus8_wins", address, 32'd24);

        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("jump_address", address, 32'h100);
        checkOutput("jump_valid_b1", {31'b0, addressValid}, 32'h0);
        checkOutput("jump_count", {16'b0, redirectCount}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("jump_valid_b2", {31'b0, addressValid}, 32'h0);
        checkOutput("jump_ignores_plus8", address, 32'h100);

        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rejump_address", address, 32'h200);
        checkOutput("rejump_count", {16'b0, redirectCount}, 32'h2);
        checkOutput("rejump_valid_b1", {31'b0, addressValid}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("rejump_valid_b2", {31'b0, addressValid}, 32'h0);
        tick();
        checkOutput("rejump_valid_back", {31'b0, addressValid}, 32'h1);
        checkOutput("rejump_address_held", address, 32'h200);

        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("wrap_setup_valid", {31'b0, addressValid}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("wrap_plus8", address, 32'h4);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        #1;
        checkOutput("flush_valid_now", {31'b0, addressValid}, 32'h0);
        tick();
        checkOutput("flush_hold_address", address, 32'h4);
        checkOutput("flush_valid", {31'b0, addressValid}, 32'h0);

        applyStimulus(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("write_beats_flush", address, 32'h40);
        checkOutput("write_beats_count", {16'b0, redirectCount}, 32'h4);

        applyStimulus(1'b1, 32'h102, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("misalign_forced", address, 32'h100);
        checkOutput("misalign_flag", {31'b0, misaligned}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("misalign_valid_back", {31'b0, addressValid}, 32'h1);

        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_address", address, 32'h0);
        checkOutput("async_reset_count", {16'b0, redirectCount}, 32'h0);
        checkOutput("async_reset_valid", {31'b0, addressValid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checkOutput("after_reset_valid", {31'b0, addressValid}, 32'h1);

        applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 1'b0);
        repeat (65540) tick();
        checkOutput("count_saturates", {16'b0, redirectCount}, 32'h0000_FFFF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("sat_valid_back", {31'b0, addressValid}, 32'h1);
        checkOutput("sat_count_held", {16'b0, redirectCount}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
